mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single SRAM-like memory port between the instruction fetch requester and the data request FIFO head. It grants one requester at a time, captures its request, and drives the bus address/data handshake with one transaction outstanding. It returns read data to the owning requester and produces the read/write stall signals that the data FIFO uses as its pop condition.

## Interface
- DATA_PRIO, 1: 1 = data side always wins a tie; 0 = round-robin between the two sides on ties.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_inst_req  in  1  fetch request pending (read only).
- i_inst_addr  in  32  fetch word address.
- o_inst_addr_ok  out  1  fetch request captured this cycle.
- o_inst_rvalid  out  1  fetch data valid, one-cycle pulse.
- o_inst_rdata  out  32  fetch data.
- i_data_valid  in  1  data FIFO head valid.
- i_data_va  in  32  head address.
- i_data_wdata  in  32  head write data.
- i_data_ren  in  1  head is a read.
- i_data_wen  in  1  head is a write.
- i_data_byteen  in  4  head byte enables.
- o_data_read_stall  out  1  0 only in the cycle a read head is captured.
- o_data_write_stall  out  1  0 only in the cycle a write head is captured.
- o_data_rvalid  out  1  load data valid, one-cycle pulse.
- o_data_rdata  out  32  load data.
- o_data_wdone  out  1  store accepted by memory, one-cycle pulse.
- o_req  out  1  bus request.
- o_wr  out  1  bus write.
- o_wstrb  out  4  bus byte strobes.
- o_addr  out  32  bus address.
- o_wdata  out  32  bus write data.
- i_addr_ok  in  1  bus accepted the address.
- i_data_ok  in  1  bus completed the transaction.
- i_rdata  in  32  bus read data, valid with i_data_ok.

## Operation
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any request is pending, arbitrate combinationally and grant exactly one requester.
  - Data grant: drive the matching stall low (read_stall when i_data_ren, else write_stall) so the FIFO pops this cycle.
  - Inst grant: pulse o_inst_addr_ok.
  - Register addr, wdata, wr = granted side's wen, wstrb (4'hF for inst), and owner; go to ADDR.
- ADDR:
  - o_req = 1 with the registered fields held stable.
  - On i_addr_ok, drop o_req the next cycle and go to DATA.
- DATA:
  - o_req = 0.
  - On i_data_ok with a read: register i_rdata into the owner's rdata and pulse its rvalid in the next cycle.
  - On i_data_ok with a write: pulse o_data_wdone in the next cycle.
  - Go to IDLE.
- Arbitration on a tie:
  - DATA_PRIO = 1: data side wins.
  - DATA_PRIO = 0: the side not granted last wins. A last-grant bit updates on every grant and resets to inst, so data wins the first tie.
- Stalls are high in every cycle other than the grant cycle, including ADDR, DATA, and while inst is granted.
- A head with neither ren nor wen is not granted.
- Requests arriving outside IDLE wait. No requester is ever granted twice for one request.

## Timing
- Reset (asynchronous, i_rst_n low):
  - FSM to IDLE, last-grant to inst.
  - o_req, o_wr, o_inst_addr_ok, o_inst_rvalid, o_data_rvalid and o_data_wdone = 0.
  - o_wstrb, o_addr, o_wdata, o_inst_rdata and o_data_rdata = 0.
  - Both stalls = 1.
- Reset mid-transaction abandons the bus transaction without a completion pulse. The bus slave is reset by the same reset.
- Grant cycle T (IDLE) → o_req = 1 from T+1.
  - addr_ok at the earliest in T+1 → DATA at T+2.
  - data_ok at the earliest in T+2 → rvalid/wdone at T+3, IDLE at T+3.
- Minimum 3 cycles per transaction; next grant is possible in T+3.
- i_addr_ok outside ADDR and i_data_ok outside DATA are ignored.
- o_inst_addr_ok and the data-side stall-low are combinational from IDLE state and the request inputs.
- o_req and the bus fields are registered.

## Test plan
- Single fetch: i_inst_req = 1, addr 0x1FC0_0000; addr_ok and data_ok each one cycle after the previous step, rdata 0xDEADBEEF.
  - o_inst_addr_ok at T.
  - o_req at T+1 with o_wr = 0 and o_wstrb = 4'hF.
  - o_inst_rvalid with 0xDEADBEEF at T+3.
- Data store: head wen = 1, va 0x8000_0010, wdata 0x1234_5678, byteen 4'b0011.
  - o_data_write_stall = 0 only at T; o_data_read_stall stays 1.
  - Bus shows o_wr = 1, o_wstrb = 4'b0011, o_addr 0x8000_0010, o_wdata 0x1234_5678.
  - o_data_wdone one cycle after data_ok.
- Tie, DATA_PRIO = 0, both sides requesting continuously for four transactions:
  - Grant order data, inst, data, inst.
  - With DATA_PRIO = 1: data, data, data, data.
- Slow slave: addr_ok withheld 5 cycles, data_ok withheld 7 cycles.
  - o_req and the bus fields stay stable throughout.
  - Stalls stay 1 and no new grant is made.
  - One rvalid pulse at the end.
- Reset asserted while in DATA:
  - All outputs go to their reset values immediately with no completion pulse.
  - After release, a pending fetch is granted in the first IDLE cycle.
- Spurious handshakes: i_data_ok pulsed in IDLE and i_addr_ok pulsed in DATA.
  - No state change and no output pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one SRAM-like memory port between the instruction fetch requester
//   and the head of the data request FIFO. One transaction is outstanding at
//   a time: grant in IDLE, present the request in ADDR until the address is
//   accepted, then wait in DATA for completion and return read data or a
//   store-done pulse to the owner.
//
// Ports
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_inst_req/i_inst_addr          fetch request (read only)
//   o_inst_addr_ok                  fetch captured this cycle (combinational)
//   o_inst_rvalid/o_inst_rdata      fetch data, one-cycle pulse
//   i_data_valid/va/wdata/ren/wen/byteen   data FIFO head
//   o_data_read_stall/write_stall   low only in the cycle the head is captured
//   o_data_rvalid/o_data_rdata      load data, one-cycle pulse
//   o_data_wdone                    store completed, one-cycle pulse
//   o_req/o_wr/o_wstrb/o_addr/o_wdata   registered bus request fields
//   i_addr_ok/i_data_ok/i_rdata     bus handshake and read data
module mem_port_arbiter #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_addr_ok,
    output logic        o_inst_rvalid,
    output logic [31:0] o_inst_rdata,
    input  logic        i_data_valid,
    input  logic [31:0] i_data_va,
    input  logic [31:0] i_data_wdata,
    input  logic        i_data_ren,
    input  logic        i_data_wen,
    input  logic [3:0]  i_data_byteen,
    output logic        o_data_read_stall,
    output logic        o_data_write_stall,
    output logic        o_data_rvalid,
    output logic [31:0] o_data_rdata,
    output logic        o_data_wdone,
    output logic        o_req,
    output logic        o_wr,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    input  logic        i_addr_ok,
    input  logic        i_data_ok,
    input  logic [31:0] i_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1 = data side won the last grant
    logic        owner_data_q, owner_data_d; // 1 = current transaction is the data side's
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        inst_rvalid_q, inst_rvalid_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        data_wdone_q, data_wdone_d;

    logic data_cand;
    logic data_wins;
    logic in_idle;
    logic grant_data;
    logic grant_inst;

    // Grants are combinational from IDLE; gating with i_rst_n keeps both
    // stalls high and addr_ok low while reset is held.
    always_comb begin
        data_cand  = i_data_valid & (i_data_ren | i_data_wen);
        data_wins  = data_cand & (~i_inst_req | DATA_PRIO | ~last_data_q);
        in_idle    = (state_q == IDLE) & i_rst_n;
        grant_data = in_idle & data_wins;
        grant_inst = in_idle & i_inst_req & ~data_wins;
    end

    always_comb begin
        state_d       = state_q;
        last_data_d   = last_data_q;
        owner_data_d  = owner_data_q;
        req_d         = req_q;
        wr_d          = wr_q;
        wstrb_d       = wstrb_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_rvalid_d = 1'b0;
        data_rdata_d  = data_rdata_q;
        data_wdone_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data || grant_inst) begin
                    state_d      = ADDR;
                    req_d        = 1'b1;
                    owner_data_d = grant_data;
                    last_data_d  = grant_data;
                    if (grant_data) begin
                        addr_d  = i_data_va;
                        wdata_d = i_data_wdata;
                        wr_d    = i_data_wen;
                        wstrb_d = i_data_byteen;
                    end else begin
                        addr_d  = i_inst_addr;
                        wdata_d = 32'h0;
                        wr_d    = 1'b0;
                        wstrb_d = 4'hF;
                    end
                end
            end
            ADDR: begin
                if (i_addr_ok) begin
                    state_d = DATA;
                    req_d   = 1'b0;
                end
            end
            DATA: begin
                if (i_data_ok) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        data_wdone_d = 1'b1;
                    end else if (owner_data_q) begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = i_rdata;
                    end else begin
                        inst_rvalid_d = 1'b1;
                        inst_rdata_d  = i_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            last_data_q   <= 1'b0;
            owner_data_q  <= 1'b0;
            req_q         <= 1'b0;
            wr_q          <= 1'b0;
            wstrb_q       <= 4'h0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= 32'h0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= 32'h0;
            data_wdone_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_data_q   <= last_data_d;
            owner_data_q  <= owner_data_d;
            req_q         <= req_d;
            wr_q          <= wr_d;
            wstrb_q       <= wstrb_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
            data_wdone_q  <= data_wdone_d;
        end
    end

    assign o_inst_addr_ok     = grant_inst;
    assign o_data_read_stall  = ~(grant_data & i_data_ren);
    assign o_data_write_stall = ~(grant_data & ~i_data_ren & i_data_wen);
    assign o_inst_rvalid      = inst_rvalid_q;
    assign o_inst_rdata       = inst_rdata_q;
    assign o_data_rvalid      = data_rvalid_q;
    assign o_data_rdata       = data_rdata_q;
    assign o_data_wdone       = data_wdone_q;
    assign o_req              = req_q;
    assign o_wr               = wr_q;
    assign o_wstrb            = wstrb_q;
    assign o_addr             = addr_q;
    assign o_wdata            = wdata_q;

endmodule
